// File: rtl/fd_pkg.sv
// fd_pkg: shared types and constants for the FAST9 address sequencer.
// Build option FD_ARC_WRAP_EN extends the circle walk with indexes 17..24,
// which repeat points 1..8, so a streaming comparator sees every 9-point arc
// that crosses from point 16 back to point 1 without storing the circle.
package fd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RADIUS = 3;

`ifdef FD_ARC_WRAP_EN
  localparam logic [4:0] LAST_IDX = 5'd24;
`else
  localparam logic [4:0] LAST_IDX = 5'd16;
`endif

  // Signed linear offset from the centre pixel for point idx of the
  // radius-3 Bresenham circle, walked clockwise starting straight above.
  function automatic int circleOffset(input logic [4:0] idx, input int columns);
    int c;
    int r;
    int off;
    logic [4:0] k;
    c   = columns;
    r   = RADIUS;
    k   = (idx > 5'd16) ? 5'(idx - 5'd16) : idx;
    off = 0;
    case (k)
      5'd1:    off = -r * c;
      5'd2:    off = -r * c + 1;
      5'd3:    off = -(r - 1) * c + (r - 1);
      5'd4:    off = -c + r;
      5'd5:    off = r;
      5'd6:    off = c + r;
      5'd7:    off = (r - 1) * c + (r - 1);
      5'd8:    off = r * c + 1;
      5'd9:    off = r * c;
      5'd10:   off = r * c - 1;
      5'd11:   off = (r - 1) * c - (r - 1);
      5'd12:   off = c - r;
      5'd13:   off = -r;
      5'd14:   off = -c - r;
      5'd15:   off = -(r - 1) * c - (r - 1);
      5'd16:   off = -r * c - 1;
      default: off = 0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/fd_addr_seq_if.sv
// fd_addr_seq_if: candidate request, SRAM read-address handshake and
// completion status of the FAST9 address sequencer. The scan controller /
// arbiter side uses the master modport, the sequencer the slave modport.
interface fd_addr_seq_if #(
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8,
  parameter int ADDR_W = 15
) ();

  logic              start;
  logic [ROW_W-1:0]  ref_row;
  logic [COL_W-1:0]  ref_col;
  logic              abort;
  logic              busy;
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [4:0]        adj_idx;
  logic              done;
  logic              oob;

  modport master (
    output start, ref_row, ref_col, abort, addr_ready,
    input  busy, addr_valid, sram_addr, adj_idx, done, oob
  );

  modport slave (
    input  start, ref_row, ref_col, abort, addr_ready,
    output busy, addr_valid, sram_addr, adj_idx, done, oob
  );

endinterface

// File: rtl/fd_offset_rom.sv
// fd_offset_rom: combinational point index -> circle offset lookup, returned
// as OFF_W-bit two's complement so it can be added modulo 2**OFF_W.
module fd_offset_rom
  import fd_pkg::*;
#(
  parameter int COLUMNS = 180,
  parameter int OFF_W   = 15
) (
  input  logic [4:0]       idx,
  output logic [OFF_W-1:0] offset
);

  // Table lookup folded to constants per index at synthesis.
  always_comb begin
    offset = OFF_W'(circleOffset(idx, COLUMNS));
  end

endmodule

// File: rtl/fd_addr_seq.sv
// fd_addr_seq: FAST9 address sequencer. Takes one candidate (row, col),
// rejects it when the radius-3 circle would leave the image, otherwise
// issues the centre address followed by the 16 circle-point addresses
// over a valid/ready handshake.
// Build option FD_ARC_WRAP_EN: continue with indexes 17..24 (points 1..8).
//
// state | meaning
// IDLE  | waiting for start
// CALC  | base address and border flag computed from captured row/col
// ISSUE | presenting sram_addr/adj_idx, advancing on each handshake
// DONE  | one-cycle done pulse, oob flags a rejected candidate
module fd_addr_seq
  import fd_pkg::*;
#(
  parameter int COLUMNS = 180,
  parameter int ROWS    = 120,
  parameter int ADDR_W  = 15,
  parameter int ROW_W   = 8,
  parameter int COL_W   = 8
) (
  input logic           clk,
  input logic           rst_n,
  fd_addr_seq_if.slave  bus
);

  if (COLUMNS * ROWS > 2 ** ADDR_W) begin : gSizeCheck
    $error("fd_addr_seq: COLUMNS*ROWS does not fit in ADDR_W address bits");
  end

  state_t            state;
  state_t            stateNext;
  logic [ROW_W-1:0]  rowReg;
  logic [COL_W-1:0]  colReg;
  logic [ADDR_W-1:0] baseReg;
  logic [ADDR_W-1:0] baseCalc;
  logic [ADDR_W-1:0] sramAddr;
  logic [ADDR_W-1:0] offset;
  logic [4:0]        adjIdx;
  logic [4:0]        romIdx;
  logic              oobFlag;
  logic              borderHit;
  logic              handshake;

  assign baseCalc  = ADDR_W'(int'(rowReg) * COLUMNS + int'(colReg));
  assign borderHit = (int'(rowReg) < RADIUS) || (int'(rowReg) > ROWS - 1 - RADIUS) ||
                     (int'(colReg) < RADIUS) || (int'(colReg) > COLUMNS - 1 - RADIUS);
  assign handshake = (state == ISSUE) && bus.addr_ready;
  // The ROM always looks one point ahead so sram_addr can be registered.
  assign romIdx    = 5'(adjIdx + 5'd1);

  fd_offset_rom #(
    .COLUMNS (COLUMNS),
    .OFF_W   (ADDR_W)
  ) uOffsetRom (
    .idx    (romIdx),
    .offset (offset)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state decode and state-derived outputs; abort overrides everything.
  always_comb begin
    stateNext      = state;
    bus.busy       = (state != IDLE);
    bus.addr_valid = (state == ISSUE);
    bus.done       = (state == DONE);
    bus.oob        = (state == DONE) && oobFlag;
    case (state)
      IDLE:    if (bus.start) stateNext = CALC;
      CALC:    stateNext = borderHit ? DONE : ISSUE;
      ISSUE:   if (handshake && (adjIdx == LAST_IDX)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (bus.abort && (state != IDLE)) stateNext = IDLE;
  end

  // Candidate capture, base/border evaluation and address/index advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowReg   <= '0;
      colReg   <= '0;
      baseReg  <= '0;
      oobFlag  <= 1'b0;
      adjIdx   <= '0;
      sramAddr <= '0;
    end else begin
      if ((state == IDLE) && bus.start) begin
        rowReg <= bus.ref_row;
        colReg <= bus.ref_col;
      end
      if (state == CALC) begin
        baseReg  <= baseCalc;
        oobFlag  <= borderHit;
        adjIdx   <= '0;
        sramAddr <= baseCalc;
      end else if (handshake && !bus.abort && (adjIdx != LAST_IDX)) begin
        adjIdx   <= romIdx;
        sramAddr <= ADDR_W'(baseReg + offset);
      end
    end
  end

  assign bus.sram_addr = sramAddr;
  assign bus.adj_idx   = adjIdx;

endmodule

// File: tb/tb_fd_addr_seq.sv
// tb_fd_addr_seq: randomized bench for fd_addr_seq. The reference model
// builds each candidate's address list from (dy, dx) circle coordinates.
module tb_fd_addr_seq;

  localparam int COLUMNS = 180;
  localparam int ROWS    = 120;
  localparam int ADDR_W  = 15;
  localparam int ROW_W   = 8;
  localparam int COL_W   = 8;
`ifdef FD_ARC_WRAP_EN
  localparam int NADDR   = 25;
`else
  localparam int NADDR   = 17;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fd_addr_seq_if #(.ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)) bus ();

  fd_addr_seq #(
    .COLUMNS (COLUMNS),
    .ROWS    (ROWS),
    .ADDR_W  (ADDR_W),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nChecks = 0;
  int nPass   = 0;
  int expQ[$];

  // Circle points as (row, col) displacements; entry 0 is the centre.
  int dyTab[17] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
  int dxTab[17] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};

  task automatic check(input string tag, input int obs, input int expd);
    nChecks++;
    if (obs == expd) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expd, $time);
  endtask

  function automatic bit offImage(input int r, input int c);
    return (r - 3 < 0) || (r + 3 > ROWS - 1) || (c - 3 < 0) || (c + 3 > COLUMNS - 1);
  endfunction

  function automatic void buildSeq(input int r, input int c);
    int p;
    expQ.delete();
    for (int k = 0; k < NADDR; k++) begin
      p = (k > 16) ? k - 16 : k;
      expQ.push_back((r + dyTab[p]) * COLUMNS + (c + dxTab[p]));
    end
  endfunction

  // Entered and left on a falling edge with the DUT idle.
  task automatic runCand(input int r, input int c, input int stallIdx, input int stallLen,
                         input int abortIdx, input bit randMode);
    int idx;
    int cycles;
    int stalled;
    bit rdy;
    bit rej;
    idx     = 0;
    cycles  = 0;
    stalled = 0;
    rej     = offImage(r, c);
    buildSeq(r, c);
    bus.start   = 1'b1;
    bus.ref_row = ROW_W'(r);
    bus.ref_col = COL_W'(c);
    @(negedge clk);
    bus.start   = randMode ? 1'($urandom % 2) : 1'b0;
    bus.ref_row = ROW_W'($urandom);
    check("calc_busy", int'(bus.busy), 1);
    check("calc_valid", int'(bus.addr_valid), 0);
    @(negedge clk);
    if (rej) begin
      check("rej_done", int'(bus.done), 1);
      check("rej_oob", int'(bus.oob), 1);
      check("rej_valid", int'(bus.addr_valid), 0);
    end else begin
      while (idx < NADDR && cycles < 500) begin
        cycles++;
        check("valid", int'(bus.addr_valid), 1);
        check("adj_idx", int'(bus.adj_idx), idx);
        check("sram_addr", int'(bus.sram_addr), expQ[idx]);
        check("in_image", int'(bus.sram_addr < ADDR_W'(COLUMNS * ROWS)), 1);
        check("done_early", int'(bus.done), 0);
        if (idx == abortIdx) begin
          bus.abort      = 1'b1;
          bus.addr_ready = 1'b1;
          bus.start      = 1'b0;
          @(negedge clk);
          bus.abort = 1'b0;
          check("abort_valid", int'(bus.addr_valid), 0);
          check("abort_busy", int'(bus.busy), 0);
          check("abort_done", int'(bus.done), 0);
          return;
        end
        rdy = randMode ? ($urandom % 4 != 0) : 1'b1;
        if (idx == stallIdx && stalled < stallLen) begin
          rdy = 1'b0;
          stalled++;
        end
        bus.addr_ready = rdy;
        bus.start      = randMode ? 1'($urandom % 2) : 1'b0;
        bus.ref_row    = ROW_W'($urandom);
        if (rdy) idx++;
        @(negedge clk);
      end
      if (cycles >= 500) check("issue_timeout", cycles, 0);
      check("done", int'(bus.done), 1);
      check("done_oob", int'(bus.oob), 0);
      check("done_valid", int'(bus.addr_valid), 0);
    end
    // A start coinciding with done must be dropped.
    bus.start = randMode;
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);
  endtask

  initial begin
    int r;
    int c;
    int ab;
    bus.start      = 1'b0;
    bus.ref_row    = '0;
    bus.ref_col    = '0;
    bus.abort      = 1'b0;
    bus.addr_ready = 1'b0;
    #12;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.addr_valid), 0);
    check("rst_addr", int'(bus.sram_addr), 0);
    check("rst_idx", int'(bus.adj_idx), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_oob", int'(bus.oob), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    runCand(3, 3, -1, 0, -1, 1'b0);
    runCand(116, 176, -1, 0, -1, 1'b0);
    runCand(2, 50, -1, 0, -1, 1'b0);
    runCand(60, 177, -1, 0, -1, 1'b0);
    runCand(3, 3, 4, 5, -1, 1'b0);
    runCand(3, 3, -1, 0, 10, 1'b0);
    runCand(10, 10, -1, 0, -1, 1'b0);

    repeat (40) begin
      r  = int'($urandom_range(0, ROWS - 1));
      c  = int'($urandom_range(0, COLUMNS - 1));
      ab = ($urandom % 6 == 0) ? int'($urandom_range(0, NADDR - 1)) : -1;
      runCand(r, c, -1, 0, ab, 1'b1);
    end

    // Asynchronous reset in the middle of an address stream.
    bus.start      = 1'b1;
    bus.ref_row    = 8'd50;
    bus.ref_col    = 8'd50;
    bus.addr_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(bus.addr_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_addr", int'(bus.sram_addr), 0);
    check("midrst_idx", int'(bus.adj_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runCand(50, 50, -1, 0, -1, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
